// File: rtl/default_block_pkg.sv
// Shared constants for the multi-channel default-block register file:
// block identity, the global register map, per-channel layout and the read default.
package default_block_pkg;

  localparam logic [15:0] BLK_ID  = 16'h0002;
  localparam logic [15:0] BLK_VER = 16'h0003;

  // Global register word addresses
  localparam logic [8:0] ADDR_ID       = 9'h000;
  localparam logic [8:0] ADDR_CONTROL  = 9'h001;
  localparam logic [8:0] ADDR_STATUS   = 9'h002;
  localparam logic [8:0] ADDR_IRQ_MASK = 9'h003;
  localparam logic [8:0] ADDR_IDX_HI   = 9'h004;
  localparam logic [8:0] ADDR_IDX_LO   = 9'h005;
  localparam logic [8:0] ADDR_ADC_LO   = 9'h006;
  localparam logic [8:0] ADDR_ADC_HI   = 9'h007;

  // Per-channel window: CH_BASE + CH_STRIDE*ch, offset in the low 3 address bits
  localparam logic [8:0] CH_BASE   = 9'h020;
  localparam int         CH_STRIDE = 8;

  typedef enum logic [2:0] {
    CH_RATIO  = 3'd0,
    CH_MASK   = 3'd1,
    CH_CORR   = 3'd2,
    CH_COUNT  = 3'd3,
    CH_FRESET = 3'd4
  } ch_reg_e;

  localparam logic [31:0] DEFAULT_RDATA = 32'hdeadbeef;
  localparam logic [4:0]  CONTROL_RST   = 5'b11110;

  // Base word address of channel ch's register window
  function automatic logic [8:0] ch_base(input int ch);
    return 9'(int'(CH_BASE) + ch * CH_STRIDE);
  endfunction

endpackage

// File: rtl/block_regs_channel.sv
// One channel's register window: decimation ratio, filter mask, correction
// enable/coefficient, saturating overflow counter and filter-reset pulse.
module block_regs_channel
  import default_block_pkg::*;
#(
  parameter int CH      = 0,
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wreq,
  input  logic [8:0]         waddr,
  input  logic [31:0]        wdata,
  input  logic               rreq,
  input  logic [8:0]         raddr,
  input  logic               overflow,
  output logic [RATIO_W-1:0] ratio,
  output logic [2:0]         filter_mask,
  output logic               corr_enable,
  output logic [15:0]        corr_coeff,
  output logic               filter_reset,
  output logic [31:0]        rdata,
  output logic               hit
);

  localparam logic [8:0] BASE = ch_base(CH);

  logic    wr_sel;
  logic    rd_sel;
  ch_reg_e wr_off;
  ch_reg_e rd_off;
  logic    cnt_clear;
  logic [CNT_W-1:0] count;

  assign wr_sel    = wreq && (waddr[8:3] == BASE[8:3]);
  assign rd_sel    = raddr[8:3] == BASE[8:3];
  assign wr_off    = ch_reg_e'(waddr[2:0]);
  assign rd_off    = ch_reg_e'(raddr[2:0]);
  assign cnt_clear = rreq && rd_sel && (rd_off == CH_COUNT);

  // Config registers and the one-cycle filter-reset strobe
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is a flop with a defined reset value; there is no RAM, so nothing is left unreset.
    if (rst) begin
      ratio        <= '0;
      filter_mask  <= '0;
      corr_enable  <= 1'b0;
      corr_coeff   <= '0;
      filter_reset <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      filter_reset <= 1'b0;
      if (wr_sel) begin
        case (wr_off)
          CH_RATIO:  ratio <= wdata[RATIO_W-1:0];
          CH_MASK:   filter_mask <= wdata[2:0];
          CH_CORR: begin
            corr_enable <= wdata[16];
            corr_coeff  <= wdata[15:0];
          end
          CH_FRESET: filter_reset <= wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Saturating overflow counter; a read-clear coinciding with an event restarts at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (cnt_clear) begin
      count <= overflow ? CNT_W'(1) : '0;
    end else if (overflow && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Read data for this window; offsets beyond the filter-reset register do not hit
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    rdata = '0;
    hit   = 1'b0;
    if (rd_sel) begin
      case (rd_off)
        CH_RATIO:  begin rdata = 32'(ratio);                       hit = 1'b1; end
        CH_MASK:   begin rdata = 32'(filter_mask);                 hit = 1'b1; end
        CH_CORR:   begin rdata = 32'({corr_enable, corr_coeff});   hit = 1'b1; end
        CH_COUNT:  begin rdata = 32'(count);                       hit = 1'b1; end
        CH_FRESET: begin rdata = '0;                               hit = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_block_regs.sv
// Up-bus register slave for NUM_CH ADC channels: global control, sticky
// status with masked interrupt, tear-free wide sample-index access and the
// read-data mux over the per-channel windows.
module multi_channel_block_regs
  import default_block_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int IDX_W   = 56,
  parameter int CNT_W   = 16,
  parameter int RATIO_W = 32
) (
  input  logic                      user_clk,
  input  logic                      user_rst,
  input  logic                      up_wreq,
  input  logic [8:0]                up_waddr,
  input  logic [31:0]               up_wdata,
  output logic                      up_wack,
  input  logic                      up_rreq,
  input  logic [8:0]                up_raddr,
  output logic [31:0]               up_rdata,
  output logic                      up_rack,
  input  logic [NUM_CH-1:0]         ch_overflow,
  input  logic                      dac_underflow,
  input  logic [IDX_W-1:0]          status_sample_idx_adc,
  output logic [4:0]                cfg_control,
  output logic [IDX_W-1:0]          cfg_sample_idx,
  output logic                      cfg_sample_idx_updated,
  output logic [NUM_CH*RATIO_W-1:0] cfg_ch_decimation_ratio,
  output logic [NUM_CH*3-1:0]       cfg_ch_filter_mask,
  output logic [NUM_CH-1:0]         cfg_ch_corr_enable,
  output logic [NUM_CH*16-1:0]      cfg_ch_corr_coeff,
  output logic [NUM_CH-1:0]         cfg_ch_filter_reset,
  output logic                      irq
);

  localparam int HI_W = IDX_W - 32;
  localparam int ST_W = NUM_CH + 1;

  logic [HI_W-1:0]   idx_staging;
  logic [HI_W-1:0]   adc_shadow;
  logic [ST_W-1:0]   status;
  logic [ST_W-1:0]   irq_mask;
  logic [ST_W-1:0]   status_clr;
  logic [ST_W-1:0]   status_set;
  logic [NUM_CH-1:0] ch_hit;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       global_rdata;
  logic [31:0]       rdata_next;

  // Per-channel register windows
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    block_regs_channel #(
      .CH      (c),
      .CNT_W   (CNT_W),
      .RATIO_W (RATIO_W)
    ) u_channel (
      .clk          (user_clk),
      .rst          (user_rst),
      .wreq         (up_wreq),
      .waddr        (up_waddr),
      .wdata        (up_wdata),
      .rreq         (up_rreq),
      .raddr        (up_raddr),
      .overflow     (ch_overflow[c]),
      .ratio        (cfg_ch_decimation_ratio[c*RATIO_W +: RATIO_W]),
      .filter_mask  (cfg_ch_filter_mask[c*3 +: 3]),
      .corr_enable  (cfg_ch_corr_enable[c]),
      .corr_coeff   (cfg_ch_corr_coeff[c*16 +: 16]),
      .filter_reset (cfg_ch_filter_reset[c]),
      .rdata        (ch_rdata[c]),
      .hit          (ch_hit[c])
    );
  end

  // Global writable registers and the sample-index commit strobe
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      up_wack                <= 1'b0;
      cfg_control            <= CONTROL_RST;
      irq_mask               <= '0;
      idx_staging            <= '0;
      cfg_sample_idx         <= '0;
      cfg_sample_idx_updated <= 1'b0;
    end else begin
      up_wack                <= up_wreq;
      cfg_sample_idx_updated <= 1'b0;
      if (up_wreq) begin
        case (up_waddr)
          ADDR_CONTROL:  cfg_control <= up_wdata[4:0];
          ADDR_IRQ_MASK: irq_mask    <= up_wdata[ST_W-1:0];
          ADDR_IDX_HI:   idx_staging <= up_wdata[HI_W-1:0];
          ADDR_IDX_LO: begin
            cfg_sample_idx         <= {idx_staging, up_wdata};
            cfg_sample_idx_updated <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Status clear sources: read-clear of the whole word plus W1C write bits
  always_comb begin
    status_clr = '0;
    if (up_rreq && (up_raddr == ADDR_STATUS)) status_clr = '1;
    if (up_wreq && (up_waddr == ADDR_STATUS)) status_clr = status_clr | up_wdata[ST_W-1:0];
  end

  assign status_set = {dac_underflow, ch_overflow};

  // Sticky status (set wins over clear) and the registered interrupt
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= (status & ~status_clr) | status_set;
      irq    <= |(status & irq_mask);
    end
  end

  // Read mux: channel windows take precedence, then the global map, else the default
  always_comb begin
    global_rdata = DEFAULT_RDATA;
    case (up_raddr)
      ADDR_ID:       global_rdata = {BLK_ID, BLK_VER};
      ADDR_CONTROL:  global_rdata = 32'(cfg_control);
      ADDR_STATUS:   global_rdata = 32'(status);
      ADDR_IRQ_MASK: global_rdata = 32'(irq_mask);
      ADDR_IDX_HI:   global_rdata = 32'(cfg_sample_idx[IDX_W-1:32]);
      ADDR_IDX_LO:   global_rdata = cfg_sample_idx[31:0];
      ADDR_ADC_LO:   global_rdata = status_sample_idx_adc[31:0];
      ADDR_ADC_HI:   global_rdata = 32'(adc_shadow);
      default: ;
    endcase
    rdata_next = global_rdata;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) rdata_next = ch_rdata[c];
    end
  end

  // Read response: data captured with the ack and held until the next read;
  // reading the ADC low word snapshots the high part for a tear-free pair
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      up_rack    <= 1'b0;
      up_rdata   <= '0;
      adc_shadow <= '0;
    end else begin
      up_rack <= up_rreq;
      if (up_rreq) begin
        up_rdata <= rdata_next;
        if (up_raddr == ADDR_ADC_LO) adc_shadow <= status_sample_idx_adc[IDX_W-1:32];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_block_regs.sv
// Self-checking bench for multi_channel_block_regs (NUM_CH=2, IDX_W=56).
// A transaction-level reference model tracks the register map; every cycle
// the DUT outputs are compared against it, plus directed spot checks.
module tb_multi_channel_block_regs;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b0;
  logic        up_wreq = 1'b0;
  logic [8:0]  up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack;
  logic        up_rreq = 1'b0;
  logic [8:0]  up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic [1:0]  ch_overflow = '0;
  logic        dac_underflow = 1'b0;
  logic [55:0] status_sample_idx_adc = '0;
  logic [4:0]  cfg_control;
  logic [55:0] cfg_sample_idx;
  logic        cfg_sample_idx_updated;
  logic [63:0] cfg_ch_decimation_ratio;
  logic [5:0]  cfg_ch_filter_mask;
  logic [1:0]  cfg_ch_corr_enable;
  logic [31:0] cfg_ch_corr_coeff;
  logic [1:0]  cfg_ch_filter_reset;
  logic        irq;

  int total = 0;
  int bad = 0;

  multi_channel_block_regs #(
    .NUM_CH(2), .IDX_W(56), .CNT_W(16), .RATIO_W(32)
  ) dut (
    .user_clk                (user_clk),
    .user_rst                (user_rst),
    .up_wreq                 (up_wreq),
    .up_waddr                (up_waddr),
    .up_wdata                (up_wdata),
    .up_wack                 (up_wack),
    .up_rreq                 (up_rreq),
    .up_raddr                (up_raddr),
    .up_rdata                (up_rdata),
    .up_rack                 (up_rack),
    .ch_overflow             (ch_overflow),
    .dac_underflow           (dac_underflow),
    .status_sample_idx_adc   (status_sample_idx_adc),
    .cfg_control             (cfg_control),
    .cfg_sample_idx          (cfg_sample_idx),
    .cfg_sample_idx_updated  (cfg_sample_idx_updated),
    .cfg_ch_decimation_ratio (cfg_ch_decimation_ratio),
    .cfg_ch_filter_mask      (cfg_ch_filter_mask),
    .cfg_ch_corr_enable      (cfg_ch_corr_enable),
    .cfg_ch_corr_coeff       (cfg_ch_corr_coeff),
    .cfg_ch_filter_reset     (cfg_ch_filter_reset),
    .irq                     (irq)
  );

  always #5 user_clk = ~user_clk;

  // Reference model state
  bit [4:0]  m_control;
  bit [2:0]  m_status;
  bit [2:0]  m_mask;
  bit [23:0] m_staging;
  bit [55:0] m_idx;
  bit [23:0] m_shadow;
  bit [31:0] m_ratio [2];
  bit [2:0]  m_fmask [2];
  bit [16:0] m_corr  [2];
  int        m_cnt   [2];
  bit [31:0] m_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_control = 5'b11110;
    m_status = '0; m_mask = '0; m_staging = '0; m_idx = '0; m_shadow = '0; m_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      m_ratio[c] = '0; m_fmask[c] = '0; m_corr[c] = '0; m_cnt[c] = 0;
    end
  endtask

  // Register map as seen by a reader
  function automatic bit [31:0] model_read(input bit [8:0] a);
    int ch, off;
    case (a)
      9'h000: return 32'h00020003;
      9'h001: return 32'(m_control);
      9'h002: return 32'(m_status);
      9'h003: return 32'(m_mask);
      9'h004: return 32'(m_idx[55:32]);
      9'h005: return m_idx[31:0];
      9'h006: return status_sample_idx_adc[31:0];
      9'h007: return 32'(m_shadow);
      default: ;
    endcase
    if (a < 9'h020) return 32'hdeadbeef;
    ch  = (int'(a) - 32) / 8;
    off = int'(a) % 8;
    if (ch >= 2) return 32'hdeadbeef;
    case (off)
      0: return m_ratio[ch];
      1: return 32'(m_fmask[ch]);
      2: return 32'(m_corr[ch]);
      3: return 32'(m_cnt[ch]);
      4: return 32'h0;
      default: return 32'hdeadbeef;
    endcase
  endfunction

  // One bus cycle: drive inputs, advance the model, check all outputs after the edge
  task automatic step(input bit we, input bit [8:0] wa, input bit [31:0] wd,
                      input bit re, input bit [8:0] ra, input bit [1:0] ovf, input bit und);
    bit [2:0] clr;
    bit       exp_irq;
    bit       exp_upd;
    bit [1:0] exp_fr;
    bit [1:0] cnt_clr;
    int       ch;
    up_wreq = we; up_waddr = wa; up_wdata = wd;
    up_rreq = re; up_raddr = ra;
    ch_overflow = ovf; dac_underflow = und;
    exp_irq = (m_status & m_mask) != 0;
    exp_upd = 1'b0; exp_fr = '0; clr = '0; cnt_clr = '0;
    if (re) begin
      m_rdata = model_read(ra);
      if (ra == 9'h002) clr = 3'b111;
      if (ra == 9'h006) m_shadow = status_sample_idx_adc[55:32];
      if (ra >= 9'h020 && ra < 9'h030 && ra[2:0] == 3'd3) cnt_clr[ra[3]] = 1'b1;
    end
    if (we) begin
      case (wa)
        9'h001: m_control = wd[4:0];
        9'h002: clr = clr | wd[2:0];
        9'h003: m_mask = wd[2:0];
        9'h004: m_staging = wd[23:0];
        9'h005: begin m_idx = {m_staging, wd}; exp_upd = 1'b1; end
        default: begin
          if (wa >= 9'h020 && wa < 9'h030) begin
            ch = int'(wa[3]);
            case (wa[2:0])
              3'd0: m_ratio[ch] = wd;
              3'd1: m_fmask[ch] = wd[2:0];
              3'd2: m_corr[ch]  = wd[16:0];
              3'd4: exp_fr[ch]  = wd[0];
              default: ;
            endcase
          end
        end
      endcase
    end
    m_status = (m_status & ~clr) | {und, ovf};
    for (int c = 0; c < 2; c++) begin
      if (cnt_clr[c]) m_cnt[c] = ovf[c] ? 1 : 0;
      else if (ovf[c] && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
    end
    @(negedge user_clk);
    up_wreq = 1'b0; up_rreq = 1'b0; ch_overflow = '0; dac_underflow = 1'b0;
    check("wack", up_wack, we);
    check("rack", up_rack, re);
    check("rdata", up_rdata, m_rdata);
    check("irq", irq, exp_irq);
    check("updated", cfg_sample_idx_updated, exp_upd);
    check("filter_reset", cfg_ch_filter_reset, exp_fr);
    check("control", cfg_control, m_control);
    check("sample_idx", cfg_sample_idx, m_idx);
    check("ratio", cfg_ch_decimation_ratio, {m_ratio[1], m_ratio[0]});
    check("fmask", cfg_ch_filter_mask, {m_fmask[1], m_fmask[0]});
    check("corr_en", cfg_ch_corr_enable, {m_corr[1][16], m_corr[0][16]});
    check("corr_coeff", cfg_ch_corr_coeff, {m_corr[1][15:0], m_corr[0][15:0]});
  endtask

  task automatic wr(input bit [8:0] a, input bit [31:0] d);
    step(1'b1, a, d, 1'b0, 9'h0, 2'b00, 1'b0);
  endtask

  task automatic rd(input bit [8:0] a);
    step(1'b0, 9'h0, 32'h0, 1'b1, a, 2'b00, 1'b0);
  endtask

  task automatic idle(input bit [1:0] ovf, input bit und);
    step(1'b0, 9'h0, 32'h0, 1'b0, 9'h0, ovf, und);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wack"}, up_wack, 1'b0);
    check({tag, "_rack"}, up_rack, 1'b0);
    check({tag, "_rdata"}, up_rdata, 32'h0);
    check({tag, "_control"}, cfg_control, 5'b11110);
    check({tag, "_idx"}, cfg_sample_idx, 56'h0);
    check({tag, "_irq"}, irq, 1'b0);
    check({tag, "_ratio"}, cfg_ch_decimation_ratio, 64'h0);
  endtask

  bit [8:0] addr_pool [14] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006,
                               9'h007, 9'h020, 9'h022, 9'h023, 9'h02B, 9'h02C, 9'h040};

  initial begin
    // 1: reset state and identity/control reads
    user_rst = 1'b1;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge user_clk);
    user_rst = 1'b0;
    rd(9'h000);
    check("blk_id", up_rdata, 32'h00020003);
    rd(9'h001);
    check("control_rst", up_rdata, 32'h0000001e);
    idle(2'b00, 1'b0);
    check("rack_one_cycle", up_rack, 1'b0);

    // 2: tear-free sample-index commit
    wr(9'h004, 32'h00ABCDEF);
    check("no_upd_on_stage", cfg_sample_idx_updated, 1'b0);
    wr(9'h005, 32'h12345678);
    check("idx_commit", cfg_sample_idx, 56'hABCDEF12345678);
    check("upd_pulse", cfg_sample_idx_updated, 1'b1);
    idle(2'b00, 1'b0);
    check("upd_single", cfg_sample_idx_updated, 1'b0);
    rd(9'h004);
    check("idx_hi_rd", up_rdata, 32'h00ABCDEF);

    // 3: sticky status and overflow counter
    for (int i = 0; i < 3; i++) idle(2'b10, 1'b0);
    rd(9'h002);
    check("status_rd1", up_rdata, 32'h2);
    rd(9'h002);
    check("status_rd2", up_rdata, 32'h0);
    rd(9'h02B);
    check("cnt_rd1", up_rdata, 32'd3);
    rd(9'h02B);
    check("cnt_rd2", up_rdata, 32'd0);
    step(1'b0, 9'h0, 32'h0, 1'b1, 9'h002, 2'b10, 1'b0);
    rd(9'h002);
    check("status_set_wins", up_rdata, 32'h2);
    step(1'b0, 9'h0, 32'h0, 1'b1, 9'h02B, 2'b10, 1'b0);
    rd(9'h02B);
    check("cnt_clr_event", up_rdata, 32'd1);
    rd(9'h002);

    // 4: masked interrupt and W1C
    wr(9'h003, 32'h4);
    idle(2'b00, 1'b1);
    check("irq_not_yet", irq, 1'b0);
    idle(2'b00, 1'b0);
    check("irq_set", irq, 1'b1);
    wr(9'h002, 32'h4);
    check("irq_still", irq, 1'b1);
    idle(2'b00, 1'b0);
    check("irq_clr", irq, 1'b0);

    // 5: ADC index snapshot
    status_sample_idx_adc = 56'h11_2233_4455_6677;
    rd(9'h006);
    check("adc_lo", up_rdata, 32'h44556677);
    status_sample_idx_adc = 56'hFF_EEDD_CCBB_AA99;
    rd(9'h007);
    check("adc_hi", up_rdata, 32'h00112233);

    // 6: channel config, filter reset pulse, out-of-range read
    wr(9'h020, 32'd10);
    check("ratio0", cfg_ch_decimation_ratio[31:0], 32'd10);
    wr(9'h024, 32'h1);
    check("freset_pulse", cfg_ch_filter_reset, 2'b01);
    rd(9'h040);
    check("freset_single", cfg_ch_filter_reset, 2'b00);
    check("oob_read", up_rdata, 32'hdeadbeef);
    rd(9'h025);
    check("unmapped_off", up_rdata, 32'hdeadbeef);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit [8:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 9'($urandom) : addr_pool[$urandom_range(0, 13)];
      ra = ($urandom_range(0, 3) == 0) ? 9'($urandom) : addr_pool[$urandom_range(0, 13)];
      if (wa == 9'h002 || wa == 9'h003 || wa[2:0] == 3'd4)
        wa = wa;
      status_sample_idx_adc = {24'($urandom), 32'($urandom)};
      step(1'($urandom), wa, $urandom, 1'($urandom), ra,
           2'($urandom_range(0, 3) == 0 ? $urandom : 0),
           1'($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of a read: no ack, state back to reset values
    up_rreq = 1'b1;
    up_raddr = 9'h001;
    #2;
    user_rst = 1'b1;
    @(negedge user_clk);
    up_rreq = 1'b0;
    model_reset();
    check_reset_state("midrst");
    @(negedge user_clk);
    user_rst = 1'b0;
    rd(9'h003);
    check("midrst_mask", up_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
